// File: rtl/imem_stream_loader_pkg.sv
// carp_loader_pkg: shared state encoding, frame constants and count type for the program loader
package carp_loader_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  typedef logic [15:0] wcount_t;
endpackage

// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: host byte stream plus program-memory write port
interface imem_stream_loader_if #(parameter int ADDR_W = 14);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_stream_loader_byte_word_packer.sv
// byte_word_packer: little-endian 8->32 assembler; word_valid pulses the cycle after the fourth byte
module byte_word_packer (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [7:0] din,
  output logic [1:0] lane,
  output logic [31:0] word,
  output logic word_valid
);
  always_ff @(posedge clk)
    if (rst) begin
      lane <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && lane == 2'd3;
      if (en) begin
        lane <= lane + 2'd1;
        word <= {din, word[31:8]};
      end
    end
endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: parses a framed byte stream into program memory and releases the core on a good checksum
module imem_stream_loader
  import carp_loader_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter logic [7:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  imem_stream_loader_if.slave bus,
  input  logic load_req,
  output logic core_hold,
  output logic load_done,
  output logic load_err
);
  state_e state, nxt;
  logic [7:0] cnt_hi, csum;
  logic [16:0] left;
  logic [ADDR_W-1:0] addr;
  logic [1:0] lane;
  logic accept, frame_start, data_en, last_byte, oversize, restart;
  wcount_t count;
  assign accept = bus.in_valid && bus.in_ready;
  assign count = {cnt_hi, bus.in_data};
  assign oversize = 32'(count) > (32'd1 << ADDR_W);
  assign frame_start = accept && state == CNT_LO;
  assign data_en = accept && state == DATA;
  // left counts words not yet written; a lane-3 accept always follows the previous word's write
  assign last_byte = data_en && lane == 2'd3 && left == 17'd1;
  assign restart = (state == DONE || state == ERROR) && load_req;
  assign bus.in_ready = state != DONE && state != ERROR;
  assign bus.imem_addr = addr;
  assign core_hold = state != DONE;
  assign load_done = state == DONE;
  assign load_err = state == ERROR;
  byte_word_packer u_pack (
    .clk(CLK),
    .rst(!RST || frame_start),
    .en(data_en),
    .din(bus.in_data),
    .lane(lane),
    .word(bus.imem_wdata),
    .word_valid(bus.imem_we)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept && bus.in_data == MAGIC ? CNT_HI : IDLE;
      CNT_HI:  nxt = accept ? CNT_LO : CNT_HI;
      CNT_LO:  nxt = !accept ? CNT_LO : count == '0 ? CSUM : oversize ? ERROR : DATA;
      DATA:    nxt = last_byte ? CSUM : DATA;
      CSUM:    nxt = !accept ? CSUM : bus.in_data == csum ? DONE : ERROR;
      default: nxt = restart ? IDLE : state;
    endcase
  end
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      cnt_hi <= '0;
      csum <= '0;
      left <= '0;
      addr <= '0;
    end else begin
      state <= nxt;
      if (accept && state == CNT_HI) cnt_hi <= bus.in_data;
      if (frame_start) begin
        csum <= '0;
        left <= 17'(count);
        addr <= '0;
      end else if (data_en) csum <= csum ^ bus.in_data;
      // the final write leaves the index on the last address rather than wrapping
      if (bus.imem_we) begin
        left <= left - 17'd1;
        if (left != 17'd1) addr <= addr + ADDR_W'(1);
      end
      if (restart) begin
        cnt_hi <= '0;
        csum <= '0;
        left <= '0;
        addr <= '0;
      end
    end
endmodule
